// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, fetches one word per cycle into a DEPTH-entry queue,
// and presents the oldest queued instruction to decode.
module fetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         controlReset,
  input  logic                         branchValid,
  input  logic [31:0]                  branchData,
  input  logic                         branchPredictValid,
  input  logic [31:0]                  branchPredictData,
  output logic [31:0]                  instructionAddress,
  output logic                         instructionRequest,
  input  logic                         instructionDataValid,
  input  logic [31:0]                  instructionData,
  input  logic                         decodeStall,
  input  logic                         decodeFlush,
  output logic                         outValid,
  output logic [31:0]                  outInstruction,
  output logic [31:0]                  outProgramCounter,
  output logic [31:0]                  outProgramCounterPlus4,
  output logic                         outPredictedTaken,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        predictedTaken;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [31:0]     pc;
  logic [31:0]     pcPlus4;
  logic [PW-1:0]   rdPtr, wrPtr;
  logic [CW-1:0]   count;
  logic            full, empty, discard, push, pop;

  assign pcPlus4 = pc + 32'd4;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

  // Redirect or flush kills both the in-flight fetch and any dequeue this cycle.
  assign discard            = branchValid || decodeFlush;
  assign instructionRequest = !full && !reset && !controlReset;
  assign push               = instructionRequest && instructionDataValid && !discard;
  assign pop                = !empty && !decodeStall && !discard && !reset && !controlReset;

  assign instructionAddress = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_VECTOR;
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (controlReset) begin
      pc    <= TRAP_VECTOR;
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (branchValid) begin
      pc    <= branchData;
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (decodeFlush) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
        pc    <= branchPredictValid ? branchPredictData : pcPlus4;
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; stale entries are never visible because outValid gates them.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= '{instruction:    instructionData,
                              pc:             pc,
                              pcPlus4:        pcPlus4,
                              predictedTaken: branchPredictValid};
  end

  assign head                   = mem[rdPtr];
  assign outValid               = !empty;
  assign outInstruction         = head.instruction;
  assign outProgramCounter      = head.pc;
  assign outProgramCounterPlus4 = head.pcPlus4;
  assign outPredictedTaken      = head.predictedTaken;
  assign occupancy              = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: queue-level reference model fed by the stimulus
// process, checked by an independent monitor sampling late in each cycle.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset, controlReset, branchValid, branchPredictValid;
  logic [31:0] branchData, branchPredictData, instructionAddress, instructionData;
  logic        instructionRequest, instructionDataValid, decodeStall, decodeFlush;
  logic        outValid, outPredictedTaken;
  logic [31:0] outInstruction, outProgramCounter, outProgramCounterPlus4;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  fetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clock(clock), .reset(reset), .controlReset(controlReset),
    .branchValid(branchValid), .branchData(branchData),
    .branchPredictValid(branchPredictValid), .branchPredictData(branchPredictData),
    .instructionAddress(instructionAddress), .instructionRequest(instructionRequest),
    .instructionDataValid(instructionDataValid), .instructionData(instructionData),
    .decodeStall(decodeStall), .decodeFlush(decodeFlush),
    .outValid(outValid), .outInstruction(outInstruction),
    .outProgramCounter(outProgramCounter), .outProgramCounterPlus4(outProgramCounterPlus4),
    .outPredictedTaken(outPredictedTaken), .occupancy(occupancy));

  always #5 clock = ~clock;

  typedef struct { logic [31:0] ins; logic [31:0] pc; logic pt; } ent_t;
  ent_t        exp_q[$];
  logic [31:0] mpc = RV;
  bit          armed = 0;
  int          vectors = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: inputs are driven at negedge, sampled 3 time units later, well before posedge.
  initial forever begin
    @(negedge clock);
    #3;
    if (armed) begin
      chk("addr", instructionAddress, mpc);
      chk("req", 32'(instructionRequest),
          32'(exp_q.size() < DEPTH && !reset && !controlReset));
      chk("valid", 32'(outValid), 32'(exp_q.size() != 0));
      chk("occ", 32'(occupancy), 32'(exp_q.size()));
      if (exp_q.size() != 0) begin
        chk("head_ins", outInstruction, exp_q[0].ins);
        chk("head_pc", outProgramCounter, exp_q[0].pc);
        chk("head_pc4", outProgramCounterPlus4, exp_q[0].pc + 32'd4);
        chk("head_pt", 32'(outPredictedTaken), 32'(exp_q[0].pt));
        if (!decodeStall && !reset && !controlReset && !branchValid && !decodeFlush)
          void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; the model applies the architectural effect after the edge.
  task automatic cyc(input bit rst, input bit crst, input bit bv, input logic [31:0] bd,
                     input bit pv, input logic [31:0] pd, input bit dv, input bit stall,
                     input bit flush);
    bit req;
    @(negedge clock);
    reset = rst; controlReset = crst; branchValid = bv; branchData = bd;
    branchPredictValid = pv; branchPredictData = pd; instructionDataValid = dv;
    instructionData = $urandom; decodeStall = stall; decodeFlush = flush;
    req = (exp_q.size() < DEPTH) && !rst && !crst;
    @(posedge clock);
    #1;
    if (rst)        begin mpc = RV; exp_q.delete(); armed = 1; end
    else if (crst)  begin mpc = TV; exp_q.delete(); end
    else if (bv)    begin mpc = bd; exp_q.delete(); end
    else if (flush) exp_q.delete();
    else if (req && dv) begin
      exp_q.push_back('{ins: instructionData, pc: mpc, pt: pv});
      mpc = pv ? pd : mpc + 32'd4;
    end
  endtask

  task automatic run(input bit dv, input bit stall, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, dv, stall, 0);
  endtask

  initial begin
    reset = 1; controlReset = 0; branchValid = 0; branchData = 0;
    branchPredictValid = 0; branchPredictData = 0; instructionDataValid = 0;
    instructionData = 0; decodeStall = 0; decodeFlush = 0;

    // Reset then stream from 0x0
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("rst_addr", instructionAddress, 32'h0);
    chk("rst_valid", 32'(outValid), 32'h0);
    run(1, 0, 3);
    chk("stream_addr", instructionAddress, 32'hC);

    // Fill under backpressure, then drain
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
    run(1, 1, 6);
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_pc", instructionAddress, 32'h10);
    run(1, 0, 6);

    // Prediction at PC 0x8
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
    run(1, 0, 2);
    cyc(0, 0, 0, 0, 1, 32'h200, 1, 1, 0);
    chk("pred_addr", instructionAddress, 32'h200);
    run(1, 0, 3);

    // Redirect with full queue
    run(1, 1, 5);
    cyc(0, 0, 1, 32'h400, 0, 0, 1, 1, 0);
    chk("redir_occ", 32'(occupancy), 32'd0);
    chk("redir_addr", instructionAddress, 32'h400);
    run(1, 0, 2);

    // Memory misses across pointer wrap
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, i[0], 0, 0);

    // Trap beats branch
    run(1, 1, 3);
    cyc(0, 1, 1, 32'h800, 0, 0, 1, 0, 0);
    chk("trap_addr", instructionAddress, TV);
    chk("trap_occ", 32'(occupancy), 32'd0);

    // Flush alone holds PC
    run(1, 1, 3);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("flush_occ", 32'(occupancy), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 4, $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 99) < 15, $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 40,
          $urandom_range(0, 99) < 3);
    run(1, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
